spi_burst_ram: RTL and testbench
================================

# spi_burst_ram

Parametrised command-driven single-port RAM that sits behind the SPI slave. It takes `{opcode, payload}` words from the SPI receive path and supports auto-incrementing writes and multi-word burst reads. Burst-read words go back to the SPI transmit path through a valid/ready handshake with backpressure.

## Interface
- `DATA_W`, 8, data word width; payload width of `din`; must be ≥ `ADDR_W`.
- `ADDR_W`, 8, address width.
- `MEM_DEPTH`, 256, number of words; must be ≤ 2**`ADDR_W`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  `DATA_W`+2  command word: `[DATA_W+1:DATA_W]` opcode, `[DATA_W-1:0]` payload.
- `rx_valid`  in  1  `din` valid.
- `rx_ready`  out  1  block can accept a command; equals (state == IDLE).
- `dout`  out  `DATA_W`  read data beat.
- `tx_valid`  out  1  `dout` valid; held until accepted.
- `tx_ready`  in  1  downstream accepts beat.
- `tx_last`  out  1  current beat is final beat of burst.
- `err`  out  1  sticky: an out-of-range address was received.

## Operation
- A command is accepted on an edge where `rx_valid && rx_ready`. When `rx_ready` = 0, `rx_valid` is ignored; no queueing, no error.
- Opcode 00, WADDR:
  - payload[`ADDR_W`-1:0] < `MEM_DEPTH` → write address `wa` loaded.
  - Otherwise `err` <= 1 and `wa` is unchanged.
- Opcode 01, WDATA: `mem[wa]` <= payload; `wa` <= `wa`+1, wrapping from `MEM_DEPTH`-1 to 0.
- Opcode 10, RADDR: `ra` loaded with the same range check and `err` rule as WADDR.
- Opcode 11, RBURST:
  - Burst length L = payload+1 (1..2**`DATA_W`); load `remaining` <= payload.
  - Go to SEND and issue the first beat.
- States:
  - IDLE: accepts commands; moves to SEND on RBURST.
  - SEND: `tx_valid` = 1. On handshake with `remaining` > 0: load next beat, decrement `remaining`. On handshake with `remaining` = 0: go to IDLE.
- Beat load, one action: `dout` <= `mem[ra]`; `ra` <= `ra`+1 with wrap; `tx_last` <= (`remaining` after this load == 0).
- After a burst, `ra` points one past the last word read (wrapped). A following RBURST with no RADDR continues sequentially.
- `err` clears only on reset.
- Memory contents are not reset. Reading an unwritten word returns X in simulation; the bench must not check it.
- Reset values: `dout` = 0, `tx_valid` = 0, `tx_last` = 0, `err` = 0, `wa` = 0, `ra` = 0, state = IDLE (so `rx_ready` = 1), `remaining` = 0.
- Reset during SEND aborts the burst: all outputs take reset values on that edge. No partial beat is retained.

## Timing
- WADDR/WDATA/RADDR: take effect on the accept edge. A WDATA followed by RBURST to the same address on the next cycle returns the new data.
- RBURST accepted on edge E0 → first beat has `tx_valid` = 1 after E0 (zero-cycle issue: beat load happens on E0 itself).
- Throughput is 1 beat/cycle while `tx_ready` = 1; no bubbles between beats.
- `dout`, `tx_last` and `tx_valid` are stable while `tx_valid && !tx_ready`.
- Last handshake on edge En → `tx_valid` = 0, `tx_last` = 0, `rx_ready` = 1 after En. Earliest next command accept is edge En+1.
- Only one memory access per cycle: writes occur only in IDLE, reads only on beat loads. This is single-port safe.

## Structure
- Shared package `spi_ram_pkg`:
  - opcode localparams `OP_WADDR`, `OP_WDATA`, `OP_RADDR`, `OP_RBURST`;
  - state typedef `ram_state_t` {IDLE, SEND}.
- One sub-module, `spi_ram_mem`: `MEM_DEPTH` × `DATA_W` array, synchronous write (`we`, `waddr`, `wdata`), combinational read (`raddr` → `rdata`).
- All registers (`dout`, `ra`, `wa`, `remaining`, state, `err`) live in `spi_burst_ram`.

## Test plan
- Reset → `rx_ready` = 1, `tx_valid` = 0, `dout` = 0, `err` = 0.
- Sequential write and read:
  - Stimulus: WADDR 0x10; WDATA 0xA1, 0xA2, 0xA3; RADDR 0x10; RBURST 2, with `tx_ready` = 1.
  - Response: beats 0xA1, 0xA2, 0xA3 on consecutive cycles; `tx_last` only on 0xA3; `rx_ready` = 1 the cycle after.
- Backpressure:
  - Stimulus: same burst, with `tx_ready` low for 3 cycles on the second beat.
  - Response: `dout` = 0xA2 held with `tx_valid` = 1; `rx_valid` pulses during SEND are ignored and memory is unchanged.
- Wrap-around:
  - Stimulus: WADDR 0xFF; WDATA 0x11, 0x22; RADDR 0xFF; RBURST 1.
  - Response: beats 0x11 (addr 0xFF) then 0x22 (addr 0x00).
- Out-of-range address:
  - Stimulus: `MEM_DEPTH` = 200, `ADDR_W` = 8; WADDR 0xC8, then WDATA 0x55.
  - Response: `err` = 1; 0x55 is written at the previous `wa`; `err` stays 1 until `rst`.
- Reset mid-burst:
  - Stimulus: RBURST 7 with `tx_ready` = 0; assert `rst` for one cycle.
  - Response: `tx_valid` = 0, `tx_last` = 0, `rx_ready` = 1, `ra` = 0 after the reset edge.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM state type for the SPI-side burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] OP_WADDR  = 2'b00;
  localparam logic [1:0] OP_WDATA  = 2'b01;
  localparam logic [1:0] OP_RADDR  = 2'b10;
  localparam logic [1:0] OP_RBURST = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ram_state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port word array: synchronous write, combinational read.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_burst_ram.sv
// Command-driven RAM behind the SPI slave: auto-increment writes and
// multi-beat burst reads returned over a valid/ready handshake.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              err
);

  ram_state_t        state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rem_q, rem_d;

  logic              mem_we;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              in_range;

  assign opcode   = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign addr_in  = payload[ADDR_W-1:0];
  assign in_range = 32'(addr_in) < MEM_DEPTH;

  // Address increment that wraps at the configured depth, not at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  spi_ram_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wa_q),
    .wdata(payload),
    .raddr(ra_q),
    .rdata(rdata)
  );

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    err_d      = err_q;
    wa_d       = wa_q;
    ra_d       = ra_q;
    rem_d      = rem_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (opcode)
            OP_WADDR: begin
              if (in_range) wa_d = addr_in;
              else          err_d = 1'b1;
            end
            OP_WDATA: begin
              mem_we = 1'b1;
              wa_d   = next_addr(wa_q);
            end
            OP_RADDR: begin
              if (in_range) ra_d = addr_in;
              else          err_d = 1'b1;
            end
            OP_RBURST: begin
              // First beat is loaded on the accept edge itself.
              dout_d     = rdata;
              ra_d       = next_addr(ra_q);
              rem_d      = payload;
              tx_last_d  = (payload == '0);
              tx_valid_d = 1'b1;
              state_d    = SEND;
            end
            default: ;
          endcase
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (rem_q != '0) begin
            dout_d    = rdata;
            ra_d      = next_addr(ra_q);
            rem_d     = rem_q - DATA_W'(1);
            tx_last_d = (rem_q == DATA_W'(1));
          end else begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      err_q      <= 1'b0;
      wa_q       <= '0;
      ra_q       <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      err_q      <= err_d;
      wa_q       <= wa_d;
      ra_q       <= ra_d;
      rem_q      <= rem_d;
    end
  end

  assign rx_ready = (state_q == IDLE);
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: full-depth instance plus a 200-word
// instance for range checking and non-power-of-two wrap.
module tb_spi_burst_ram;

  localparam logic [1:0] WADDR  = 2'b00;
  localparam logic [1:0] WDATA  = 2'b01;
  localparam logic [1:0] RADDR  = 2'b10;
  localparam logic [1:0] RBURST = 2'b11;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, tx_last, err;
  logic [7:0] dout;

  logic [9:0] din2;
  logic       rx_valid2, rx_ready2, tx_valid2, tx_ready2, tx_last2, err2;
  logic [7:0] dout2;

  int n_total = 0;
  int n_bad   = 0;

  spi_burst_ram u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .dout    (dout),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_last (tx_last),
    .err     (err)
  );

  spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_dut200 (
    .clk     (clk),
    .rst     (rst),
    .din     (din2),
    .rx_valid(rx_valid2),
    .rx_ready(rx_ready2),
    .dout    (dout2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .tx_last (tx_last2),
    .err     (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    din      = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic cmd2(input logic [1:0] op, input logic [7:0] pl);
    din2      = {op, pl};
    rx_valid2 = 1'b1;
    tick();
    rx_valid2 = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_data"},  32'(dout), 32'(d));
    check({tag, "_last"},  32'(tx_last), 32'(last));
  endtask

  task automatic idle_after(input string tag);
    check({tag, "_valid"},   32'(tx_valid), 32'd0);
    check({tag, "_last"},    32'(tx_last), 32'd0);
    check({tag, "_rxready"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; din = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    din2 = '0; rx_valid2 = 1'b0; tx_ready2 = 1'b1;
    tick(); tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_dout",     32'(dout), 32'd0);
    check("rst_err",      32'(err), 32'd0);
    check("rst_tx_last",  32'(tx_last), 32'd0);
    rst = 1'b0;

    // Sequential write then 3-beat burst at full throughput.
    cmd(WADDR, 8'h10);
    cmd(WDATA, 8'hA1); cmd(WDATA, 8'hA2); cmd(WDATA, 8'hA3);
    cmd(RADDR, 8'h10);
    cmd(RBURST, 8'd2);
    beat("seq_b0", 8'hA1, 1'b0);
    check("seq_rxready_busy", 32'(rx_ready), 32'd0);
    tick(); beat("seq_b1", 8'hA2, 1'b0);
    tick(); beat("seq_b2", 8'hA3, 1'b1);
    tick(); idle_after("seq_end");

    // Backpressure on the second beat with ignored commands during SEND.
    cmd(RADDR, 8'h10);
    tx_ready = 1'b0;
    cmd(RBURST, 8'd2);
    beat("bp_b0", 8'hA1, 1'b0);
    tx_ready = 1'b1;
    tick(); beat("bp_b1", 8'hA2, 1'b0);
    tx_ready = 1'b0;
    din = {WADDR, 8'h00}; rx_valid = 1'b1; tick(); beat("bp_hold0", 8'hA2, 1'b0);
    din = {WDATA, 8'h99};                  tick(); beat("bp_hold1", 8'hA2, 1'b0);
    din = {RADDR, 8'h00};                  tick(); beat("bp_hold2", 8'hA2, 1'b0);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(); beat("bp_b2", 8'hA3, 1'b1);
    tick(); idle_after("bp_end");
    // wa must still be 0x13 and ra must be 0x13 (ignored RADDR).
    cmd(WDATA, 8'hA4);
    cmd(RBURST, 8'd0);
    beat("bp_wa_kept", 8'hA4, 1'b1);
    tick(); idle_after("bp_wa_end");

    // Write immediately followed by a read of the same word.
    cmd(RADDR, 8'h41);
    cmd(WADDR, 8'h41);
    cmd(WDATA, 8'h5A);
    cmd(RBURST, 8'd0);
    beat("wr_rd", 8'h5A, 1'b1);
    tick();

    // Wrap from 0xFF to 0x00 on both write and read.
    cmd(WADDR, 8'hFF);
    cmd(WDATA, 8'h11); cmd(WDATA, 8'h22);
    cmd(RADDR, 8'hFF);
    cmd(RBURST, 8'd1);
    beat("wrap_b0", 8'h11, 1'b0);
    tick(); beat("wrap_b1", 8'h22, 1'b1);
    tick(); idle_after("wrap_end");
    check("wrap_err", 32'(err), 32'd0);

    // 200-word instance: boundary address 199 wraps to 0.
    cmd2(WADDR, 8'hC7);
    cmd2(WDATA, 8'h77); cmd2(WDATA, 8'h88);
    cmd2(RADDR, 8'hC7);
    cmd2(RBURST, 8'd1);
    check("d200_b0", 32'(dout2), 32'h77);
    tick();
    check("d200_b1", 32'(dout2), 32'h88);
    check("d200_b1_last", 32'(tx_last2), 32'd1);
    tick();
    check("d200_err_ok", 32'(err2), 32'd0);

    // Out-of-range WADDR: err set, wa unchanged so data lands at 0x06.
    cmd2(WADDR, 8'h05);
    cmd2(WDATA, 8'h33);
    cmd2(WADDR, 8'hC8);
    check("oor_err", 32'(err2), 32'd1);
    cmd2(WDATA, 8'h55);
    cmd2(RADDR, 8'h06);
    cmd2(RBURST, 8'd0);
    check("oor_data", 32'(dout2), 32'h55);
    tick();
    check("oor_err_sticky", 32'(err2), 32'd1);
    check("main_err_clear", 32'(err), 32'd0);

    // Reset mid-burst aborts everything; ra returns to 0 (mem[0]=0x22).
    tx_ready = 1'b0;
    cmd(RADDR, 8'h10);
    cmd(RBURST, 8'd7);
    beat("mid_b0", 8'hA1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_after("mid_rst");
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_err2", 32'(err2), 32'd0);
    tx_ready = 1'b1;
    cmd(RBURST, 8'd0);
    beat("mid_ra0", 8'h22, 1'b1);
    tick(); idle_after("mid_end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
